axi_interconnect_crossbar_mresp_route: RTL and testbench
========================================================

# axi_interconnect_crossbar_mresp_route

Return-path router of the crossbar, at the downstream master port. It takes response beats carrying a slave-index tag in their low bits and steers each beat to the originating slave port. Read data uses the last flag; write responses are single-beat. Each slave port has a 2-entry skid buffer, and per-slave outstanding-transaction accounting guards against unmatched responses.

## Interface
Parameters:
- MODE_READ, 1: 1 = read-data channel (last flag = MSB of info); 0 = write-response channel (every beat is last).
- NUM_SLAVE, 2: number of slave ports (1..4).
- WIDTH_RESPINFO, 48: response payload width, excluding the tag.
- NUM_OUTSTANDING, 4: maximum open transactions per slave port.
- WIDTH_SLAVE, LOG2(NUM_SLAVE-1): tag width (minimum 1).
- WIDTH_OSCNT, LOG2(NUM_OUTSTANDING): outstanding counter width.
- U_DLY, 1: register assignment delay.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- resp_info  in  WIDTH_RESPINFO+WIDTH_SLAVE  {payload, tag}; tag is in the low WIDTH_SLAVE bits.
- resp_valid  in  1  downstream beat valid.
- resp_ready  out  1  beat accepted.
- s_resp_info  out  NUM_SLAVE*WIDTH_RESPINFO  per-port payload.
- s_resp_valid  out  NUM_SLAVE  per-port valid.
- s_resp_ready  in  NUM_SLAVE  per-port ready.
- issue_valid  in  1  request issued downstream (addr_valid & addr_ready of the request arbiter).
- issue_slave  in  WIDTH_SLAVE  slave index of the issued request.
- s_os_full  out  NUM_SLAVE  port has NUM_OUTSTANDING open transactions; the arbiter masks its request.
- err_unexp  out  1  one-cycle pulse on an unmatched or out-of-range response.

## Operation
- sel = resp_info[WIDTH_SLAVE-1:0]; last = MODE_READ ? resp_info[MSB] : 1.
- resp_ready is combinational:
  - 1 if sel ≥ NUM_SLAVE: the beat is drained and dropped.
  - otherwise ~buf_full[sel].
- A beat is accepted on resp_valid & resp_ready and is written into skid buffer sel the same edge.
- Skid buffer per port: 2 entries, FIFO order.
  - s_resp_valid[i] = ~empty[i].
  - s_resp_info[i] = head payload, tag stripped.
  - Pop on s_resp_valid[i] & s_resp_ready[i].
  - Simultaneous push and pop while full is impossible because resp_ready is low; push and pop with 1 entry keeps 1 entry.
- Outstanding counter os_cnt[i], WIDTH_OSCNT+1 bits:
  - +1 on issue_valid with issue_slave == i.
  - −1 on an accepted last beat with sel == i.
  - Both in the same cycle: unchanged.
  - s_os_full[i] = (os_cnt[i] == NUM_OUTSTANDING).
- Error cases; each pulses err_unexp for one cycle and leaves counters unchanged:
  - Accepted beat with os_cnt[sel] == 0, or sel ≥ NUM_SLAVE: beat dropped, not forwarded.
  - Issue while s_os_full: counter saturates.
- Responses to different ports never block each other. Only the addressed buffer back-pressures.

## Timing
- Latency: accepted beat appears on s_resp_valid the next cycle.
- Throughput: 1 beat/cycle per port under continuous s_resp_ready.
- Reset values: s_resp_valid 0, s_resp_info 0, os_cnt 0, s_os_full 0, err_unexp 0.
- resp_ready is combinational and follows buffer state after reset.
- Reset mid-burst: buffers and counters clear immediately, and partial bursts are discarded. The upstream side is reset by the same rst_n.
- A port with a full buffer and s_resp_ready low holds resp_ready low indefinitely for beats tagged to it. AXI ordering requires this.

## Configuration
- AXI_IC_RESP_CHECK_EN defined: outstanding counters, s_os_full, and err_unexp are implemented as described above.
- AXI_IC_RESP_CHECK_EN undefined:
  - Counters are removed; s_os_full and err_unexp are tied 0.
  - Beats with sel < NUM_SLAVE are always forwarded; out-of-range beats are still dropped silently.
  - issue_valid and issue_slave are ignored.

## Structure
- Shared package axi_interconnect_pkg holds:
  - the LOG2 function;
  - default WIDTH_RESPINFO and NUM_OUTSTANDING constants;
  - the tag-field position constant.
- Sub-module axi_interconnect_resp_skid: 2-entry valid/ready buffer with parameter width, instantiated NUM_SLAVE times in a generate loop.
- Counters and error logic are in the top module under the macro guard.

## Test plan
- Single route: NUM_SLAVE=2, MODE_READ=1; issue to slave 1, then 4-beat burst tagged 1, last on beat 4, s_resp_ready=1 → 4 beats on port 1 one cycle after each acceptance; port 0 idle; os_cnt[1] goes 1→0.
- Back-pressure: s_resp_ready[0]=0, 3 beats tagged 0 → first 2 accepted; resp_ready low on the third until one pop, then accepted the next cycle; order preserved.
- Non-blocking: port 0 buffer full and stalled, beat tagged 1 arrives → accepted immediately and forwarded on port 1.
- Outstanding limit: 4 issues to slave 0 → s_os_full[0]=1; a fifth issue → err_unexp pulse, count stays 4; issue and last-beat retire in the same cycle → count stays 4.
- Unexpected: MODE_READ=0, response tagged 0 with os_cnt[0]=0 → err_unexp one cycle, no s_resp_valid; tag 3 with NUM_SLAVE=2 → dropped, pulse. With the macro undefined, the in-range tag-0 beat is forwarded and err_unexp stays 0.
- Reset mid-burst: assert rst_n low after beat 2 of 4 → all s_resp_valid go 0 asynchronously and os_cnt clears.

Source files
------------

// File: rtl/axi_interconnect_pkg.sv
// rtl/axi_interconnect_pkg.sv - shared constants and helpers for the crossbar
//
// Purpose: default widths/depths, the position of the slave-index tag within
// a response word, and the LOG2 sizing function used for tag and counter
// widths.
package axi_interconnect_pkg;

  localparam int DEF_WIDTH_RESPINFO  = 48;
  localparam int DEF_NUM_OUTSTANDING = 4;

  // The slave-index tag occupies the low bits of every response word.
  localparam int TAG_LSB = 0;

  // Number of bits needed to represent value (never less than 1), so that
  // LOG2(NUM_SLAVE-1) can encode every slave index and LOG2(N) plus one bit
  // of headroom can hold the count N itself.
  function automatic int LOG2(input int value);
    int bits;
    bits = 1;
    for (int b = 1; b < 31; b++) begin
      if (value >= (1 << b)) bits = b + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/axi_interconnect_resp_skid.sv
// rtl/axi_interconnect_resp_skid.sv - 2-entry FIFO skid buffer for one slave port
//
// Purpose: holds up to two response payloads in arrival order.
// Ports:
//   clk_sys, rst_n  clock, asynchronous active-low reset
//   push_valid      write push_data this edge (caller never pushes when full)
//   push_data       payload to store
//   full            both entries occupied
//   head_valid      buffer not empty
//   head_data       oldest payload (0 after reset)
//   pop_ready       consumer takes the head when head_valid is also high
module axi_interconnect_resp_skid #(
  parameter int WIDTH = 48
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  input  logic             pop_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             pop;

  assign pop        = head_valid & pop_ready;
  assign full       = (count == 2'd2);
  assign head_valid = (count != 2'd0);
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_valid) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      // Push and pop together leave the occupancy unchanged.
      case ({push_valid, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_interconnect_crossbar_mresp_route.sv
// rtl/axi_interconnect_crossbar_mresp_route.sv - steers tagged response beats back to slave ports
//
// Purpose: return-path router at a downstream master port. Each beat carries
// the originating slave index in its low tag bits; the beat is written into
// that slave's 2-entry skid buffer. Out-of-range tags are drained and dropped.
// Optional feature macro: AXI_IC_RESP_CHECK_EN enables per-slave outstanding
// counters, s_os_full and err_unexp; without it those outputs are tied 0.
// Ports:
//   clk_sys, rst_n   clock, asynchronous active-low reset
//   resp_info        {payload, tag}; read mode: payload MSB is the last flag
//   resp_valid       downstream beat valid
//   resp_ready       combinational accept (only the addressed buffer stalls)
//   s_resp_info      per-port payload, tag stripped
//   s_resp_valid     per-port valid
//   s_resp_ready     per-port ready
//   issue_valid      request issued downstream
//   issue_slave      slave index of the issued request
//   s_os_full        port holds NUM_OUTSTANDING open transactions
//   err_unexp        one-cycle pulse on unmatched/out-of-range beat or overflow
module axi_interconnect_crossbar_mresp_route
  import axi_interconnect_pkg::*;
#(
  parameter int MODE_READ       = 1,
  parameter int NUM_SLAVE       = 2,
  parameter int WIDTH_RESPINFO  = DEF_WIDTH_RESPINFO,
  parameter int NUM_OUTSTANDING = DEF_NUM_OUTSTANDING,
  parameter int WIDTH_SLAVE     = LOG2(NUM_SLAVE - 1),
  parameter int WIDTH_OSCNT     = LOG2(NUM_OUTSTANDING),
  parameter int U_DLY           = 1
) (
  input  logic                                clk_sys,
  input  logic                                rst_n,
  input  logic [WIDTH_RESPINFO+WIDTH_SLAVE-1:0] resp_info,
  input  logic                                resp_valid,
  output logic                                resp_ready,
  output logic [NUM_SLAVE*WIDTH_RESPINFO-1:0] s_resp_info,
  output logic [NUM_SLAVE-1:0]                s_resp_valid,
  input  logic [NUM_SLAVE-1:0]                s_resp_ready,
  input  logic                                issue_valid,
  input  logic [WIDTH_SLAVE-1:0]              issue_slave,
  output logic [NUM_SLAVE-1:0]                s_os_full,
  output logic                                err_unexp
);

  localparam int WIDTH_INFO = WIDTH_RESPINFO + WIDTH_SLAVE;
  localparam int NUM_TAG    = 1 << WIDTH_SLAVE;

  if (NUM_SLAVE < 1 || NUM_SLAVE > 4 || NUM_OUTSTANDING < 1 ||
      WIDTH_OSCNT < 1 || U_DLY < 0) begin : g_bad_cfg
    $error("axi_interconnect_crossbar_mresp_route: unsupported parameters");
  end

  logic [WIDTH_SLAVE-1:0]    sel;
  logic [WIDTH_RESPINFO-1:0] payload;
  logic                      last;
  logic                      sel_oob;
  logic                      accept;
  logic                      beat_ok;
  logic [NUM_SLAVE-1:0]      sel_hot;
  logic [NUM_SLAVE-1:0]      buf_full;
  logic [NUM_SLAVE-1:0]      push;
  logic [NUM_TAG-1:0]        full_by_tag;

  assign sel     = resp_info[TAG_LSB +: WIDTH_SLAVE];
  assign payload = resp_info[TAG_LSB + WIDTH_SLAVE +: WIDTH_RESPINFO];
  assign last    = (MODE_READ != 0) ? resp_info[WIDTH_INFO-1] : 1'b1;

  for (genvar i = 0; i < NUM_SLAVE; i++) begin : g_sel
    assign sel_hot[i] = (sel == WIDTH_SLAVE'(i));
  end
  assign sel_oob = ~|sel_hot;

  // Tags with no port behind them read as "not full" so they always drain.
  always_comb begin
    full_by_tag = '0;
    for (int i = 0; i < NUM_SLAVE; i++) full_by_tag[i] = buf_full[i];
  end

  assign resp_ready = ~full_by_tag[sel];
  assign accept     = resp_valid & resp_ready;
  assign push       = (accept & beat_ok) ? sel_hot : '0;

  for (genvar i = 0; i < NUM_SLAVE; i++) begin : g_port
    axi_interconnect_resp_skid #(
      .WIDTH(WIDTH_RESPINFO)
    ) u_skid (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .push_valid (push[i]),
      .push_data  (payload),
      .full       (buf_full[i]),
      .head_valid (s_resp_valid[i]),
      .head_data  (s_resp_info[i*WIDTH_RESPINFO +: WIDTH_RESPINFO]),
      .pop_ready  (s_resp_ready[i])
    );
  end

`ifdef AXI_IC_RESP_CHECK_EN
  logic [WIDTH_OSCNT:0] os_cnt [NUM_SLAVE];
  logic [NUM_SLAVE-1:0] os_zero;
  logic [NUM_SLAVE-1:0] inc;
  logic [NUM_SLAVE-1:0] dec;
  logic [NUM_SLAVE-1:0] over;

  for (genvar i = 0; i < NUM_SLAVE; i++) begin : g_os
    assign os_zero[i]   = (os_cnt[i] == '0);
    assign inc[i]       = issue_valid & (issue_slave == WIDTH_SLAVE'(i));
    assign dec[i]       = push[i] & last;
    assign s_os_full[i] = (os_cnt[i] == (WIDTH_OSCNT+1)'(NUM_OUTSTANDING));
    // An issue that meets a retire in the same cycle is a net no-op, even
    // at the limit; only an unmatched issue at the limit overflows.
    assign over[i]      = inc[i] & ~dec[i] & s_os_full[i];

    always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
        os_cnt[i] <= '0;
      end else if (inc[i] & ~dec[i] & ~s_os_full[i]) begin
        os_cnt[i] <= os_cnt[i] + 1'b1;
      end else if (dec[i] & ~inc[i]) begin
        os_cnt[i] <= os_cnt[i] - 1'b1;
      end
    end
  end

  // A beat for a port with nothing open is unmatched and is dropped.
  assign beat_ok = ~sel_oob & ~|(sel_hot & os_zero);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) err_unexp <= 1'b0;
    else        err_unexp <= (accept & ~beat_ok) | (|over);
  end
`else
  logic unused_check;

  assign beat_ok      = ~sel_oob;
  assign s_os_full    = '0;
  assign err_unexp    = 1'b0;
  assign unused_check = ^{issue_valid, issue_slave, last};
`endif

endmodule

// File: tb/tb_axi_interconnect_crossbar_mresp_route.sv
// tb/tb_axi_interconnect_crossbar_mresp_route.sv - self-checking bench for the response router
module tb_axi_interconnect_crossbar_mresp_route;

`ifdef AXI_IC_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [49:0] resp_info;
  logic        resp_valid;
  wire         resp_ready;
  wire  [95:0] s_resp_info;
  wire  [1:0]  s_resp_valid;
  logic [1:0]  s_resp_ready;
  logic        issue_valid;
  logic [1:0]  issue_slave;
  wire  [1:0]  s_os_full;
  wire         err_unexp;

  logic [48:0] w_resp_info;
  logic        w_resp_valid;
  wire         w_resp_ready;
  wire  [95:0] w_s_resp_info;
  wire  [1:0]  w_s_resp_valid;
  logic [1:0]  w_s_resp_ready;
  logic        w_issue_valid;
  logic [0:0]  w_issue_slave;
  wire  [1:0]  w_s_os_full;
  wire         w_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  axi_interconnect_crossbar_mresp_route #(
    .MODE_READ(1), .NUM_SLAVE(2), .WIDTH_RESPINFO(48),
    .NUM_OUTSTANDING(4), .WIDTH_SLAVE(2)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .resp_info(resp_info), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .s_resp_info(s_resp_info), .s_resp_valid(s_resp_valid),
    .s_resp_ready(s_resp_ready), .issue_valid(issue_valid),
    .issue_slave(issue_slave), .s_os_full(s_os_full), .err_unexp(err_unexp)
  );

  axi_interconnect_crossbar_mresp_route #(
    .MODE_READ(0), .NUM_SLAVE(2), .WIDTH_RESPINFO(48), .NUM_OUTSTANDING(4)
  ) dut_wr (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .resp_info(w_resp_info), .resp_valid(w_resp_valid), .resp_ready(w_resp_ready),
    .s_resp_info(w_s_resp_info), .s_resp_valid(w_s_resp_valid),
    .s_resp_ready(w_s_resp_ready), .issue_valid(w_issue_valid),
    .issue_slave(w_issue_slave), .s_os_full(w_s_os_full), .err_unexp(w_err)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model of the main (read-mode) instance: one FIFO queue and one open
  // transaction count per port, plus the error flag raised by the last edge.
  logic [47:0] mq [2][$];
  int          os_m [2];
  bit          err_m;
  int          m_sel;
  bit          m_acc;
  bit          m_lst;
  bit          m_e;
  bit          m_inc;
  bit          m_dec [2];

  function automatic bit m_ready();
    int s;
    s = int'(resp_info[1:0]);
    if (s >= 2) return 1'b1;
    return mq[s].size() < 2;
  endfunction

  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        os_m[i] = 0;
      end
      err_m = 1'b0;
    end else begin
      m_e   = 1'b0;
      m_sel = int'(resp_info[1:0]);
      m_lst = resp_info[49];
      m_acc = resp_valid && m_ready();
      for (int i = 0; i < 2; i++) begin
        m_dec[i] = 1'b0;
        if (mq[i].size() > 0 && s_resp_ready[i]) void'(mq[i].pop_front());
      end
      if (m_acc) begin
        if (m_sel >= 2) m_e = CHK;
        else if (CHK && os_m[m_sel] == 0) m_e = 1'b1;
        else begin
          mq[m_sel].push_back(resp_info[49:2]);
          if (CHK && m_lst) m_dec[m_sel] = 1'b1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        m_inc = CHK && issue_valid && (int'(issue_slave) == i);
        if (m_inc && !m_dec[i]) begin
          if (os_m[i] == 4) m_e = 1'b1;
          else os_m[i]++;
        end else if (m_dec[i] && !m_inc) begin
          os_m[i]--;
        end
      end
      err_m = m_e;
    end
  end

  always @(negedge clk_sys) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_valid%0d", i), s_resp_valid[i], mq[i].size() > 0);
        if (mq[i].size() > 0)
          chk($sformatf("model_info%0d", i), s_resp_info[i*48 +: 48], mq[i][0]);
      end
      chk("model_resp_ready", resp_ready, m_ready());
      chk("model_os_full", s_os_full, {os_m[1] == 4, os_m[0] == 4});
      chk("model_err", err_unexp, err_m);
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic beat(input logic [1:0] tag, input logic lst, input logic [46:0] data);
    resp_valid = 1'b1;
    resp_info  = {lst, data, tag};
  endtask

  task automatic reset_dut();
    resp_valid = 1'b0; issue_valid = 1'b0; s_resp_ready = 2'b00;
    w_resp_valid = 1'b0; w_issue_valid = 1'b0; w_s_resp_ready = 2'b00;
    #1 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [47:0] exp_p;
    resp_info = '0; resp_valid = 1'b0; s_resp_ready = 2'b00;
    issue_valid = 1'b0; issue_slave = 2'd0;
    w_resp_info = '0; w_resp_valid = 1'b0; w_s_resp_ready = 2'b00;
    w_issue_valid = 1'b0; w_issue_slave = 1'b0;
    #12;
    chk("rst_valid", s_resp_valid, 2'b00);
    chk("rst_info", s_resp_info, 96'h0);
    chk("rst_os_full", s_os_full, 2'b00);
    chk("rst_err", err_unexp, 1'b0);
    chk("rst_ready", resp_ready, 1'b1);
    tick();
    rst_n = 1'b1;

    // Single route: 4-beat burst to port 1.
    issue_valid = 1'b1; issue_slave = 2'd1;
    tick();
    issue_valid = 1'b0;
    s_resp_ready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      beat(2'd1, b == 3, 47'h0A00 + 47'(b));
      tick();
      exp_p = {1'(b == 3), 47'h0A00 + 47'(b)};
      chk($sformatf("route_valid%0d", b), s_resp_valid, 2'b10);
      chk($sformatf("route_info%0d", b), s_resp_info[95:48], exp_p);
    end
    resp_valid = 1'b0;
    tick();
    chk("route_idle", s_resp_valid, 2'b00);
    beat(2'd1, 1'b1, 47'h1);
    tick();
    resp_valid = 1'b0;
    chk("route_retired_err", err_unexp, CHK);
    chk("route_retired_valid", s_resp_valid, CHK ? 2'b00 : 2'b10);

    // Back-pressure on port 0.
    reset_dut();
    issue_valid = 1'b1; issue_slave = 2'd0;
    tick();
    issue_valid = 1'b0;
    beat(2'd0, 1'b0, 47'hB0); tick();
    beat(2'd0, 1'b0, 47'hB1); tick();
    beat(2'd0, 1'b1, 47'hB2);
    #1 chk("bp_ready_low", resp_ready, 1'b0);
    tick();
    chk("bp_still_low", resp_ready, 1'b0);
    s_resp_ready = 2'b01;
    tick();
    chk("bp_head_b1", s_resp_info[47:0], {1'b0, 47'hB1});
    chk("bp_ready_back", resp_ready, 1'b1);
    tick();
    chk("bp_head_b2", s_resp_info[47:0], {1'b1, 47'hB2});
    resp_valid = 1'b0;
    tick();
    chk("bp_drained", s_resp_valid, 2'b00);

    // Port 0 full and stalled must not block port 1.
    reset_dut();
    issue_valid = 1'b1; issue_slave = 2'd0; tick();
    issue_slave = 2'd1; tick();
    issue_valid = 1'b0;
    s_resp_ready = 2'b10;
    beat(2'd0, 1'b0, 47'hC0); tick();
    beat(2'd0, 1'b0, 47'hC1); tick();
    beat(2'd1, 1'b1, 47'hD0);
    #1 chk("nb_ready", resp_ready, 1'b1);
    tick();
    resp_valid = 1'b0;
    chk("nb_valid", s_resp_valid, 2'b11);
    chk("nb_info1", s_resp_info[95:48], {1'b1, 47'hD0});
    beat(2'd0, 1'b0, 47'hC2);
    #1 chk("nb_port0_blocked", resp_ready, 1'b0);
    resp_valid = 1'b0;

    // Outstanding limit on port 0.
    reset_dut();
    issue_valid = 1'b1; issue_slave = 2'd0;
    repeat (4) tick();
    chk("os_full4", s_os_full, CHK ? 2'b01 : 2'b00);
    chk("os_no_err", err_unexp, 1'b0);
    tick();
    chk("os_over_err", err_unexp, CHK);
    issue_valid = 1'b0;
    tick();
    chk("os_err_one_cycle", err_unexp, 1'b0);
    chk("os_stays_full", s_os_full, CHK ? 2'b01 : 2'b00);
    issue_valid = 1'b1; s_resp_ready = 2'b11;
    beat(2'd0, 1'b1, 47'hE0);
    tick();
    issue_valid = 1'b0; resp_valid = 1'b0;
    chk("os_swap_full", s_os_full, CHK ? 2'b01 : 2'b00);
    chk("os_swap_no_err", err_unexp, 1'b0);
    chk("os_swap_fwd", s_resp_valid, 2'b01);
    beat(2'd0, 1'b1, 47'hE1);
    tick();
    resp_valid = 1'b0;
    chk("os_retire_not_full", s_os_full, 2'b00);

    // Unexpected and out-of-range beats.
    reset_dut();
    s_resp_ready = 2'b11;
    beat(2'd0, 1'b1, 47'hF0);
    tick();
    resp_valid = 1'b0;
    chk("unexp_err", err_unexp, CHK);
    chk("unexp_valid", s_resp_valid, CHK ? 2'b00 : 2'b01);
    tick();
    chk("unexp_pulse_end", err_unexp, 1'b0);
    beat(2'd3, 1'b1, 47'hF3);
    #1 chk("oob_ready", resp_ready, 1'b1);
    tick();
    resp_valid = 1'b0;
    chk("oob_err", err_unexp, CHK);
    chk("oob_valid", s_resp_valid, 2'b00);

    // Write-response instance: every beat is last.
    w_s_resp_ready = 2'b11;
    w_resp_valid = 1'b1; w_resp_info = {48'h8000_0000_00F0, 1'b0};
    tick();
    w_resp_valid = 1'b0;
    chk("wr_unexp_err", w_err, CHK);
    chk("wr_unexp_valid", w_s_resp_valid, CHK ? 2'b00 : 2'b01);
    tick();
    w_issue_valid = 1'b1; w_issue_slave = 1'b1;
    tick();
    w_issue_valid = 1'b0;
    w_resp_valid = 1'b1; w_resp_info = {48'h123, 1'b1};
    tick();
    chk("wr_fwd_valid", w_s_resp_valid, 2'b10);
    chk("wr_fwd_info", w_s_resp_info[95:48], 48'h123);
    chk("wr_fwd_err", w_err, 1'b0);
    chk("wr_os_full", w_s_os_full, 2'b00);
    w_resp_info = {48'h456, 1'b1};
    tick();
    w_resp_valid = 1'b0;
    chk("wr_single_beat_err", w_err, CHK);
    chk("wr_ready", w_resp_ready, 1'b1);

    // Reset in the middle of a burst.
    reset_dut();
    issue_valid = 1'b1; issue_slave = 2'd1;
    tick();
    issue_valid = 1'b0;
    beat(2'd1, 1'b0, 47'h60); tick();
    beat(2'd1, 1'b0, 47'h61); tick();
    chk("rst_mid_pre", s_resp_valid, 2'b10);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_valid", s_resp_valid, 2'b00);
    chk("rst_mid_os_full", s_os_full, 2'b00);
    resp_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    s_resp_ready = 2'b11;
    beat(2'd1, 1'b1, 47'h62);
    tick();
    resp_valid = 1'b0;
    chk("rst_mid_os_clear_err", err_unexp, CHK);
    chk("rst_mid_os_clear_valid", s_resp_valid, CHK ? 2'b00 : 2'b10);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
